// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and default sizing for the SDRAM read/write port arbiter.
package sdram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int ADDR_W_DEF       = 20;
    localparam int DATA_W_DEF       = 16;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int TIMEOUT_DEF      = 255;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the display reader and camera writer onto one SDRAM controller.
// Reads win by default; a write that keeps losing is eventually forced through.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic              ctrl_start_read,
    output logic              ctrl_start_write,
    input  logic              ctrl_busy,
    input  logic [DATA_W-1:0] ctrl_read_pixel,
    input  logic              ctrl_read_valid,
    input  logic              ctrl_write_done,
    output logic              timeout_err
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [SC_W-1:0] starve_cnt;
    logic [TO_W-1:0] tcnt;
    logic            rd_win;
    logic            wr_win;

    always_comb begin
        rd_win = rd_req && (starve_cnt < SC_W'(STARVE_LIMIT));
        wr_win = !rd_win && wr_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            starve_cnt       <= '0;
            tcnt             <= '0;
            rd_ack           <= 1'b0;
            wr_ack           <= 1'b0;
            rd_valid         <= 1'b0;
            ctrl_start_read  <= 1'b0;
            ctrl_start_write <= 1'b0;
            ctrl_addr        <= '0;
            ctrl_wdata       <= '0;
            rd_data          <= '0;
            timeout_err      <= 1'b0;
        end else begin
            rd_ack           <= 1'b0;
            wr_ack           <= 1'b0;
            rd_valid         <= 1'b0;
            ctrl_start_read  <= 1'b0;
            ctrl_start_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ctrl_busy) begin
                        if (rd_win) begin
                            ctrl_addr       <= rd_addr;
                            rd_ack          <= 1'b1;
                            ctrl_start_read <= 1'b1;
                            tcnt            <= '0;
                            state           <= READ;
                            // rd_win guarantees starve_cnt < STARVE_LIMIT, so this saturates
                            if (wr_req)
                                starve_cnt <= starve_cnt + SC_W'(1);
                        end else if (wr_win) begin
                            ctrl_addr        <= wr_addr;
                            ctrl_wdata       <= wr_data;
                            wr_ack           <= 1'b1;
                            ctrl_start_write <= 1'b1;
                            tcnt             <= '0;
                            starve_cnt       <= '0;
                            state            <= WRITE;
                        end
                    end
                end
                READ: begin
                    if (ctrl_read_valid) begin
                        rd_data  <= ctrl_read_pixel;
                        rd_valid <= 1'b1;
                        state    <= IDLE;
                    end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                WRITE: begin
                    if (ctrl_write_done) begin
                        state <= IDLE;
                    end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
